hazard_ctrl: RTL and testbench

- Pipeline hazard/stall sequencer for the 5-stage MIPS core.
- Sits beside the forwarding unit and drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Covers data-memory waits, load-use bubbles (the one hazard forwarding cannot cover), instruction-fetch waits, branch/jump redirect refetch and sticky halt.
- Keeps saturating stall/flush performance counters and a data-memory wait watchdog.

---
 rtl/cpu_types_pkg.sv | 10 +
 rtl/hazard_pkg.sv | 54 +++++
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/sat_counter.sv | 18 +
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: opcode encoding used across pipeline control blocks.
package cpu_types_pkg;

    typedef logic [5:0] opcode_t;

    localparam opcode_t RTYPE = 6'b000000;
    localparam opcode_t LW    = 6'b100011;
    localparam opcode_t SW    = 6'b101011;

endpackage

// File: rtl/hazard_pkg.sv
// Hazard sequencer types: FSM state, per-cycle winning condition and the latch control bundle.
package hazard_pkg;

    localparam int CNTW_DEF    = 16;
    localparam int MAXWAIT_DEF = 255;

    typedef enum logic [1:0] {RUN, DWAIT, REFETCH, HALT} hz_state_t;

    typedef enum logic [2:0] {
        C_NONE, C_HALTED, C_HALTWB, C_DSTALL, C_REDIR, C_LU, C_ISTALL
    } hz_cond_t;

    typedef struct packed {
        logic pcEN;
        logic enIFID;
        logic enIDEX;
        logic enEXMEM;
        logic enMEMWB;
        logic flushIFID;
        logic flushIDEX;
        logic flushEXMEM;
    } hz_ctl_t;

    // Flushes are synchronous clears, so a flushed latch keeps its enable high.
    function automatic hz_ctl_t ctlFor(hz_cond_t cond);
        hz_ctl_t c;
        c = '0;
        unique case (cond)
            C_REDIR: c = '1;
            C_LU: begin
                c           = '1;
                c.pcEN      = 1'b0;
                c.enIFID    = 1'b0;
                c.flushIFID = 1'b0;
                c.flushEXMEM = 1'b0;
            end
            C_ISTALL: begin
                c            = '1;
                c.pcEN       = 1'b0;
                c.flushIDEX  = 1'b0;
                c.flushEXMEM = 1'b0;
            end
            C_NONE: begin
                c            = '1;
                c.flushIFID  = 1'b0;
                c.flushIDEX  = 1'b0;
                c.flushEXMEM = 1'b0;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, PC/latch controls and perf counters out.
interface hazard_ctrl_if #(parameter int CNTW = 16);

    logic                   ihit;
    logic                   dhit;
    logic                   memreqMEM;
    cpu_types_pkg::opcode_t opcodeEX;
    logic [4:0]             rtEX;
    logic [4:0]             rsID;
    logic [4:0]             rtID;
    logic                   usesRtID;
    logic                   redirectMEM;
    logic                   haltWB;

    logic                   pcEN;
    logic                   enIFID;
    logic                   enIDEX;
    logic                   enEXMEM;
    logic                   enMEMWB;
    logic                   flushIFID;
    logic                   flushIDEX;
    logic                   flushEXMEM;
    logic                   halted;
    logic                   timeout;
    logic [CNTW-1:0]        stallCnt;
    logic [CNTW-1:0]        flushCnt;

    modport hc (
        input  ihit, dhit, memreqMEM, opcodeEX, rtEX, rsID, rtID, usesRtID,
               redirectMEM, haltWB,
        output pcEN, enIFID, enIDEX, enEXMEM, enMEMWB, flushIFID, flushIDEX,
               flushEXMEM, halted, timeout, stallCnt, flushCnt
    );

    modport tb (
        output ihit, dhit, memreqMEM, opcodeEX, rtEX, rsID, rtID, usesRtID,
               redirectMEM, haltWB,
        input  pcEN, enIFID, enIDEX, enEXMEM, enMEMWB, flushIFID, flushIDEX,
               flushEXMEM, halted, timeout, stallCnt, flushCnt
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall sequencer: picks the highest-priority hazard each cycle and
// drives PC/latch enables and flushes, plus stall/flush counters and a DWAIT watchdog.
//   state   | meaning
//   RUN     | normal issue; istall/lu handled without leaving RUN
//   DWAIT   | data memory access outstanding, whole pipe frozen
//   REFETCH | redirect taken, waiting for the target fetch to complete
//   HALT    | HALT retired; everything frozen until reset
module hazard_ctrl
    import hazard_pkg::*, cpu_types_pkg::*;
#(
    parameter int CNTW    = CNTW_DEF,
    parameter int MAXWAIT = MAXWAIT_DEF
) (
    input logic        CLK,
    input logic        RST,
    hazard_ctrl_if.hc  hif
);

    localparam int WW = (MAXWAIT < 2) ? 1 : $clog2(MAXWAIT + 1);

    hz_state_t     state;
    hz_cond_t      cond;
    hz_ctl_t       ctl;
    logic          refPend;
    logic [WW-1:0] waitCnt;
    logic          halted;
    logic          timeout;
    logic          dstall;
    logic          lu;
    logic          istall;
    logic          stallInc;
    logic          flushInc;

    assign dstall = hif.memreqMEM & ~hif.dhit;
    assign lu     = (hif.opcodeEX == LW) && (hif.rtEX != 5'd0) &&
                    ((hif.rtEX == hif.rsID) || (hif.usesRtID && (hif.rtEX == hif.rtID)));
    assign istall = ~hif.ihit;

    // REFETCH-wait produces the same controls as an istall, so it shares C_ISTALL.
    always_comb begin
        cond = C_NONE;
        if (state == HALT)        cond = C_HALTED;
        else if (hif.haltWB)      cond = C_HALTWB;
        else if (dstall)          cond = C_DSTALL;
        else if (hif.redirectMEM) cond = C_REDIR;
        else if (lu)              cond = C_LU;
        else if (istall)          cond = C_ISTALL;
    end

    always_comb begin
        ctl = '0;
        if (!RST)
            ctl = ctlFor(cond);
    end

    assign stallInc = (cond == C_DSTALL) || (cond == C_LU) || (cond == C_ISTALL);
    assign flushInc = (cond == C_REDIR);

    // refPend remembers an unfinished refetch across a DWAIT detour.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= RUN;
            refPend <= 1'b0;
            waitCnt <= '0;
            halted  <= 1'b0;
            timeout <= 1'b0;
        end else if (state != HALT) begin
            if (cond == C_REDIR)
                refPend <= 1'b1;
            else if (hif.ihit)
                refPend <= 1'b0;

            if (cond == C_DSTALL) begin
                if (int'(waitCnt) < MAXWAIT)
                    waitCnt <= waitCnt + WW'(1);
                if (int'(waitCnt) + 1 >= MAXWAIT)
                    timeout <= 1'b1;
            end else begin
                waitCnt <= '0;
            end

            unique case (cond)
                C_HALTWB: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
                C_DSTALL: state <= DWAIT;
                C_REDIR:  state <= REFETCH;
                default:  state <= (refPend && !hif.ihit) ? REFETCH : RUN;
            endcase
        end
    end

    assign hif.pcEN       = ctl.pcEN;
    assign hif.enIFID     = ctl.enIFID;
    assign hif.enIDEX     = ctl.enIDEX;
    assign hif.enEXMEM    = ctl.enEXMEM;
    assign hif.enMEMWB    = ctl.enMEMWB;
    assign hif.flushIFID  = ctl.flushIFID;
    assign hif.flushIDEX  = ctl.flushIDEX;
    assign hif.flushEXMEM = ctl.flushEXMEM;
    assign hif.halted     = halted;
    assign hif.timeout    = timeout;

    sat_counter #(.W(CNTW)) uStallCnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stallInc),
        .count (hif.stallCnt)
    );

    sat_counter #(.W(CNTW)) uFlushCnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flushInc),
        .count (hif.flushCnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (wide counters / tiny counters and watchdog)
// checked every cycle against a priority-rule model, plus directed literal checks.
module tb_hazard_ctrl;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic       ihit, dhit, memreq, usesRt, redirect, haltWB;
    opcode_t    opcodeEX;
    logic [4:0] rtEX, rsID, rtID;

    hazard_ctrl_if #(.CNTW(16)) ifA ();
    hazard_ctrl_if #(.CNTW(4))  ifB ();

    assign ifA.ihit = ihit;         assign ifB.ihit = ihit;
    assign ifA.dhit = dhit;         assign ifB.dhit = dhit;
    assign ifA.memreqMEM = memreq;  assign ifB.memreqMEM = memreq;
    assign ifA.opcodeEX = opcodeEX; assign ifB.opcodeEX = opcodeEX;
    assign ifA.rtEX = rtEX;         assign ifB.rtEX = rtEX;
    assign ifA.rsID = rsID;         assign ifB.rsID = rsID;
    assign ifA.rtID = rtID;         assign ifB.rtID = rtID;
    assign ifA.usesRtID = usesRt;   assign ifB.usesRtID = usesRt;
    assign ifA.redirectMEM = redirect; assign ifB.redirectMEM = redirect;
    assign ifA.haltWB = haltWB;     assign ifB.haltWB = haltWB;

    hazard_ctrl #(.CNTW(16), .MAXWAIT(255)) dutA (.CLK(CLK), .RST(RST), .hif(ifA.hc));
    hazard_ctrl #(.CNTW(4),  .MAXWAIT(2))   dutB (.CLK(CLK), .RST(RST), .hif(ifB.hc));

    int total = 0;
    int bad   = 0;

    // Model state per instance: 0 = CNTW 16 / MAXWAIT 255, 1 = CNTW 4 / MAXWAIT 2
    bit mHalt[2];
    bit mTo[2];
    int mWait[2];
    int mStall[2];
    int mFlush[2];
    int cap[2] = '{65535, 15};
    int mx[2]  = '{255, 2};

    // Control vector order: pcEN, enIFID, enIDEX, enEXMEM, enMEMWB, flushIFID, flushIDEX, flushEXMEM
    localparam logic [7:0] V_FROZEN = 8'h00;
    localparam logic [7:0] V_REDIR  = 8'hFF;
    localparam logic [7:0] V_LU     = 8'h3A;
    localparam logic [7:0] V_ISTALL = 8'h7C;
    localparam logic [7:0] V_RUN    = 8'hF8;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit isLu();
        return (opcodeEX == LW) && (rtEX != 0) &&
               ((rtEX == rsID) || (usesRt && (rtEX == rtID)));
    endfunction

    function automatic logic [7:0] expCtl(int k);
        if (RST || mHalt[k] || haltWB) return V_FROZEN;
        if (memreq && !dhit)           return V_FROZEN;
        if (redirect)                  return V_REDIR;
        if (isLu())                    return V_LU;
        if (!ihit)                     return V_ISTALL;
        return V_RUN;
    endfunction

    function automatic logic [7:0] ctlA();
        return {ifA.pcEN, ifA.enIFID, ifA.enIDEX, ifA.enEXMEM, ifA.enMEMWB,
                ifA.flushIFID, ifA.flushIDEX, ifA.flushEXMEM};
    endfunction

    function automatic logic [7:0] ctlB();
        return {ifB.pcEN, ifB.enIFID, ifB.enIDEX, ifB.enEXMEM, ifB.enMEMWB,
                ifB.flushIFID, ifB.flushIDEX, ifB.flushEXMEM};
    endfunction

    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (RST) begin
                mHalt[k] = 0; mTo[k] = 0; mWait[k] = 0; mStall[k] = 0; mFlush[k] = 0;
            end else if (!mHalt[k]) begin
                if (haltWB) begin
                    mHalt[k] = 1;
                    mWait[k] = 0;
                end else if (memreq && !dhit) begin
                    mStall[k] = (mStall[k] < cap[k]) ? mStall[k] + 1 : cap[k];
                    mWait[k]++;
                    if (mWait[k] >= mx[k]) mTo[k] = 1;
                end else begin
                    mWait[k] = 0;
                    if (redirect)
                        mFlush[k] = (mFlush[k] < cap[k]) ? mFlush[k] + 1 : cap[k];
                    else if (isLu() || !ihit)
                        mStall[k] = (mStall[k] < cap[k]) ? mStall[k] + 1 : cap[k];
                end
            end
        end
    end

    always @(negedge CLK) begin
        check("ctlA", 32'(ctlA()), 32'(expCtl(0)));
        check("ctlB", 32'(ctlB()), 32'(expCtl(1)));
        check("haltedA", 32'(ifA.halted), RST ? 0 : 32'(mHalt[0]));
        check("haltedB", 32'(ifB.halted), RST ? 0 : 32'(mHalt[1]));
        check("timeoutA", 32'(ifA.timeout), RST ? 0 : 32'(mTo[0]));
        check("timeoutB", 32'(ifB.timeout), RST ? 0 : 32'(mTo[1]));
        check("stallCntA", 32'(ifA.stallCnt), RST ? 0 : mStall[0]);
        check("stallCntB", 32'(ifB.stallCnt), RST ? 0 : mStall[1]);
        check("flushCntA", 32'(ifA.flushCnt), RST ? 0 : mFlush[0]);
        check("flushCntB", 32'(ifB.flushCnt), RST ? 0 : mFlush[1]);
    end

    task automatic setIdle();
        ihit = 1; dhit = 1; memreq = 0; usesRt = 0; redirect = 0; haltWB = 0;
        opcodeEX = RTYPE; rtEX = 0; rsID = 0; rtID = 0;
    endtask

    task automatic toNeg();
        @(negedge CLK); #1;
    endtask

    task automatic toPos();
        @(posedge CLK); #1;
    endtask

    int rstCnt = 0;

    initial begin
        setIdle();
        toNeg();
        check("rst_ctl", 32'(ctlA()), 32'(V_FROZEN));
        check("rst_stall", 32'(ifA.stallCnt), 0);
        toPos(); toPos();
        RST = 0;
        repeat (3) begin
            toNeg(); check("idle_ctl", 32'(ctlA()), 32'(V_RUN)); toPos();
        end
        toNeg(); check("idle_stall", 32'(ifA.stallCnt), 0); toPos();

        // load-use bubble
        opcodeEX = LW; rtEX = 5; rsID = 5;
        toNeg(); check("lu_ctl", 32'(ctlA()), 32'(V_LU)); toPos();
        setIdle();
        toNeg(); check("lu_after", 32'(ctlA()), 32'(V_RUN));
        check("lu_stall", 32'(ifA.stallCnt), 1); toPos();

        // rtEX = 0 never stalls
        opcodeEX = LW; rtEX = 0; rsID = 0; rtID = 0; usesRt = 1;
        toNeg(); check("lu_r0_ctl", 32'(ctlA()), 32'(V_RUN)); toPos();
        setIdle();
        toNeg(); check("lu_r0_stall", 32'(ifA.stallCnt), 1); toPos();

        // data wait of three cycles
        memreq = 1; dhit = 0;
        repeat (3) begin
            toNeg(); check("dwait_ctl", 32'(ctlA()), 32'(V_FROZEN)); toPos();
        end
        dhit = 1;
        toNeg();
        check("dwait_exit", 32'(ctlA()), 32'(V_RUN));
        check("dwait_stall", 32'(ifA.stallCnt), 4);
        check("dwait_toB", 32'(ifB.timeout), 1);
        check("dwait_toA", 32'(ifA.timeout), 0);
        toPos();
        setIdle();
        toNeg(); check("to_sticky", 32'(ifB.timeout), 1); toPos();

        // redirect then two-cycle refetch
        redirect = 1;
        toNeg(); check("redir_ctl", 32'(ctlA()), 32'(V_REDIR)); toPos();
        redirect = 0; ihit = 0;
        repeat (2) begin
            toNeg(); check("refetch_ctl", 32'(ctlA()), 32'(V_ISTALL)); toPos();
        end
        ihit = 1;
        toNeg();
        check("refetch_done", 32'(ctlA()), 32'(V_RUN));
        check("redir_flush", 32'(ifA.flushCnt), 1);
        check("redir_stall", 32'(ifA.stallCnt), 6);
        toPos();

        // halt is sticky
        haltWB = 1;
        toNeg(); check("haltwb_ctl", 32'(ctlA()), 32'(V_FROZEN));
        check("haltwb_halted", 32'(ifA.halted), 0); toPos();
        repeat (5) begin
            haltWB = 0; ihit = 1'($urandom); memreq = 1'($urandom);
            redirect = 1'($urandom); dhit = 1'($urandom);
            toNeg(); check("halt_ctl", 32'(ctlA()), 32'(V_FROZEN));
            check("halt_halted", 32'(ifA.halted), 1); toPos();
        end

        // asynchronous reset in the middle of a data wait
        RST = 1; setIdle(); toPos();
        RST = 0; memreq = 1; dhit = 0;
        toPos(); toPos();
        toNeg(); check("pre_rst_stall", 32'(ifA.stallCnt), 2);
        RST = 1; #1;
        check("async_rst_stall", 32'(ifA.stallCnt), 0);
        check("async_rst_ctl", 32'(ctlA()), 32'(V_FROZEN));
        toPos(); toPos();
        setIdle(); RST = 0;

        // saturation of the 4-bit counter
        ihit = 0;
        repeat (20) toPos();
        setIdle();
        toNeg();
        check("sat_stallB", 32'(ifB.stallCnt), 15);
        check("sat_stallA", 32'(ifA.stallCnt), 20);
        toPos();

        repeat (4000) begin
            if (rstCnt > 0) begin
                RST = 1; rstCnt--;
            end else begin
                RST = 0;
                if ($urandom_range(0, 199) == 0 || (mHalt[0] && $urandom_range(0, 19) == 0))
                    rstCnt = 2;
            end
            ihit     = ($urandom_range(0, 9) < 7);
            dhit     = ($urandom_range(0, 9) < 6);
            memreq   = ($urandom_range(0, 9) < 3);
            opcodeEX = ($urandom_range(0, 2) == 0) ? LW : opcode_t'($urandom_range(0, 63));
            rtEX     = 5'($urandom_range(0, 3));
            rsID     = 5'($urandom_range(0, 3));
            rtID     = 5'($urandom_range(0, 3));
            usesRt   = 1'($urandom);
            redirect = ($urandom_range(0, 9) == 0);
            haltWB   = ($urandom_range(0, 299) == 0);
            toPos();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
